// File: rtl/ising_ctrl_pkg.sv
// Shared types for the Ising run sequencer: FSM state encoding and counter width.
// Helper converts a programmed cycle length to a down-counter load value (0 acts as 1).
package ising_ctrl_pkg;

    localparam int ST_W  = 3;
    localparam int CNT_W = 32;

    typedef enum logic [ST_W-1:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        RUN    = 3'd2,
        SAMPLE = 3'd3,
        OUTPUT = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] len_to_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

endpackage

// File: rtl/ising_run_ctrl_if.sv
// Host write bus, core write bus and result valid/ready port of the run sequencer.
// master = sequencer side, slave = host/core environment side.
interface ising_run_ctrl_if #(
    parameter int N     = 3,
    parameter int RUN_W = 16
);
    logic             host_wready;
    logic [31:0]      host_wr_addr;
    logic [31:0]      host_wdata;
    logic             core_wready;
    logic [31:0]      core_wr_addr;
    logic [31:0]      core_wdata;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_phase;
    logic [RUN_W-1:0] res_index;

    modport master (
        input  host_wready, host_wr_addr, host_wdata, res_ready,
        output core_wready, core_wr_addr, core_wdata,
        output res_valid, res_phase, res_index
    );

    modport slave (
        output host_wready, host_wr_addr, host_wdata, res_ready,
        input  core_wready, core_wr_addr, core_wdata,
        input  res_valid, res_phase, res_index
    );
endinterface

// File: rtl/cycle_timer.sv
// Loadable 32-bit down-counter timing one sequencer phase; len 0 behaves as 1.
// expire is high in the len-th cycle after load; no backpressure, load has priority.
module cycle_timer
    import ising_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= len_to_load(len);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/ising_run_ctrl.sv
// Ising run sequencer: HOLD/RUN/SAMPLE per run, result out over valid/ready, N runs per batch.
// Result valid one cycle after the last SAMPLE cycle; res_ready low stalls in OUTPUT with payload held.
module ising_run_ctrl
    import ising_ctrl_pkg::*;
#(
    parameter int N     = 3,
    parameter int RUN_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [RUN_W-1:0]  num_runs,
    input  logic [CNT_W-1:0]  hold_cycles,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic [CNT_W-1:0]  sample_cycles,
    input  logic [N-1:0]      phase_in,
    output logic              ising_rstn,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              wr_err,
    ising_run_ctrl_if.master  bus
);

    state_t           state, state_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_len;
    logic             tmr_expire;
    logic             cfg_load, capture, idx_clr, idx_inc, done_set, abort_set;
    logic [RUN_W-1:0] num_runs_q, run_idx, run_idx_nxt;
    logic [CNT_W-1:0] hold_q, run_q, sample_q;
    logic             is_idle;

    assign is_idle     = (state == IDLE);
    assign run_idx_nxt = run_idx + RUN_W'(1);

    cycle_timer u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_len   = hold_q;
        cfg_load  = 1'b0;
        capture   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        done_set  = 1'b0;
        abort_set = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cfg_load = 1'b1;
                    idx_clr  = 1'b1;
                    if (num_runs == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                        tmr_load  = 1'b1;
                        tmr_len   = hold_cycles;
                    end
                end
            end
            HOLD: begin
                if (tmr_expire) begin
                    state_nxt = RUN;
                    tmr_load  = 1'b1;
                    tmr_len   = run_q;
                end
            end
            RUN: begin
                if (tmr_expire) begin
                    state_nxt = SAMPLE;
                    tmr_load  = 1'b1;
                    tmr_len   = sample_q;
                end
            end
            SAMPLE: begin
                if (tmr_expire) begin
                    state_nxt = OUTPUT;
                    capture   = 1'b1;
                end
            end
            OUTPUT: begin
                if (bus.res_ready) begin
                    idx_inc = 1'b1;
                    if (run_idx_nxt == num_runs_q) begin
                        state_nxt = IDLE;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                        tmr_load  = 1'b1;
                        tmr_len   = hold_q;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a handshake completing this cycle.
        if (!is_idle && abort) begin
            state_nxt = IDLE;
            tmr_load  = 1'b0;
            capture   = 1'b0;
            idx_inc   = 1'b0;
            done_set  = 1'b0;
            abort_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_runs_q    <= '0;
            hold_q        <= '0;
            run_q         <= '0;
            sample_q      <= '0;
            run_idx       <= '0;
            bus.res_phase <= '0;
            bus.res_index <= '0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            done    <= done_set;
            aborted <= abort_set;
            if (cfg_load) begin
                num_runs_q <= num_runs;
                hold_q     <= hold_cycles;
                run_q      <= run_cycles;
                sample_q   <= sample_cycles;
            end
            if (idx_clr) begin
                run_idx <= '0;
            end else if (idx_inc) begin
                run_idx <= run_idx_nxt;
            end
            if (capture) begin
                bus.res_phase <= phase_in;
                bus.res_index <= run_idx;
            end
            if (cfg_load) begin
                wr_err <= 1'b0;
            end else if (!is_idle && bus.host_wready) begin
                wr_err <= 1'b1;
            end
        end
    end

    assign busy          = !is_idle;
    assign ising_rstn    = (state == RUN) || (state == SAMPLE) || (state == OUTPUT);
    assign bus.res_valid = (state == OUTPUT);

    // Writes reach the core only while the oscillators are held in reset.
    assign bus.core_wready  = is_idle && bus.host_wready;
    assign bus.core_wr_addr = bus.core_wready ? bus.host_wr_addr : '0;
    assign bus.core_wdata   = bus.core_wready ? bus.host_wdata   : '0;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: per-cycle status checks plus a result scoreboard.
module tb_ising_run_ctrl;

    localparam int N     = 3;
    localparam int RUN_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start, abort;
    logic [RUN_W-1:0] num_runs;
    logic [31:0]      hold_cycles, run_cycles, sample_cycles;
    logic [N-1:0]     phase_in;
    logic             ising_rstn, busy, done, aborted, wr_err;

    ising_run_ctrl_if #(.N(N), .RUN_W(RUN_W)) bus ();

    ising_run_ctrl #(.N(N), .RUN_W(RUN_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .abort         (abort),
        .num_runs      (num_runs),
        .hold_cycles   (hold_cycles),
        .run_cycles    (run_cycles),
        .sample_cycles (sample_cycles),
        .phase_in      (phase_in),
        .ising_rstn    (ising_rstn),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .wr_err        (wr_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [N+RUN_W-1:0] sb_q[$];
    logic [N+RUN_W-1:0] mon_exp;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // {ising_rstn, res_valid, busy, done, aborted}
    function automatic logic [4:0] st();
        return {ising_rstn, bus.res_valid, busy, done, aborted};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted result must match the next expected {phase, index}.
    always @(negedge clk) begin
        if (rstn && bus.res_valid && bus.res_ready && !abort) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL result_unexpected: got phase %b index %0d, expected no result",
                         bus.res_phase, bus.res_index);
            end else begin
                mon_exp = sb_q.pop_front();
                check("result", {bus.res_phase, bus.res_index}, mon_exp);
            end
        end
    end

    // Full batch with res_ready tied high; checks the status vector every cycle.
    task automatic run_batch(input string nm, input int h_in, input int r_in, input int s_in,
                             input int nr, input logic [N-1:0] ph);
        int h, r, s, len, pos;
        logic [4:0] e;
        h = (h_in == 0) ? 1 : h_in;
        r = (r_in == 0) ? 1 : r_in;
        s = (s_in == 0) ? 1 : s_in;
        len = h + r + s + 1;
        num_runs      = RUN_W'(nr);
        hold_cycles   = h_in;
        run_cycles    = r_in;
        sample_cycles = s_in;
        phase_in      = ph;
        bus.res_ready = 1'b1;
        for (int i = 0; i < nr; i++) sb_q.push_back({ph, RUN_W'(i)});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= nr * len + 1; k++) begin
            if (k > 1) step();
            @(negedge clk);
            pos = (k - 1) % len + 1;
            if (k <= nr * len) e = {pos > h, pos == len, 1'b1, 1'b0, 1'b0};
            else               e = 5'b00010;
            check($sformatf("%s_k%0d", nm, k), st(), e);
        end
        step();
    endtask

    task automatic wait_done(input int max_cyc);
        bit found;
        found = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
            step();
        end
        check("done_seen", found, 1);
        if (found) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] e;
        rstn = 1'b0;
        start = 1'b0; abort = 1'b0;
        num_runs = '0; hold_cycles = '0; run_cycles = '0; sample_cycles = '0;
        phase_in = '0;
        bus.host_wready = 1'b0; bus.host_wr_addr = '0; bus.host_wdata = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_vals", {ising_rstn, busy, done, aborted, bus.res_valid, wr_err, bus.core_wready,
                             bus.res_phase, bus.res_index, bus.core_wr_addr, bus.core_wdata}, 0);
        rstn = 1'b1;
        step();

        // Basic batch: two runs, H=2 R=5 S=3, done in the cycle after the second handshake.
        run_batch("basic", 2, 5, 3, 2, 3'b101);

        // Backpressure: result held for 10 stalled cycles while phase_in toggles.
        num_runs = 2; hold_cycles = 1; run_cycles = 1; sample_cycles = 1;
        phase_in = 3'b011; bus.res_ready = 1'b0;
        sb_q.push_back({3'b011, 16'd0});
        sb_q.push_back({3'b110, 16'd1});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) step();
            bus.res_ready = (k >= 14);
            if (k >= 14)     phase_in = 3'b110;
            else if (k >= 4) phase_in = (k % 2 == 1) ? 3'b100 : 3'b011;
            @(negedge clk);
            if (k == 1 || k == 15)             e = 5'b00100;
            else if (k <= 3 || k == 16 || k == 17) e = 5'b10100;
            else if (k <= 14 || k == 18)       e = 5'b11100;
            else                               e = 5'b00010;
            check($sformatf("bp_k%0d", k), st(), e);
            if (k >= 4 && k <= 14)
                check($sformatf("bp_payload_k%0d", k), {bus.res_phase, bus.res_index}, {3'b011, 16'd0});
        end
        step();

        // Zero config: num_runs=0 completes immediately without going busy.
        num_runs = 0;
        start = 1'b1;
        @(negedge clk);
        check("zero_runs_start_cyc", st(), 5'b00000);
        step();
        start = 1'b0;
        @(negedge clk);
        check("zero_runs_done", st(), 5'b00010);
        step();
        @(negedge clk);
        check("zero_runs_after", st(), 5'b00000);
        step();

        // Zero lengths: every phase lasts exactly one cycle.
        run_batch("zero_len", 0, 0, 0, 1, 3'b111);

        // Write pass-through in IDLE is combinational.
        bus.host_wready = 1'b1; bus.host_wr_addr = 32'h0000_1234; bus.host_wdata = 32'hCAFE_F00D;
        #1;
        check("wr_idle_pass", {bus.core_wready, bus.core_wr_addr, bus.core_wdata},
              {1'b1, 32'h0000_1234, 32'hCAFE_F00D});
        bus.host_wready = 1'b0;
        #1;
        check("wr_idle_release", bus.core_wready, 0);
        @(negedge clk);
        check("wr_idle_no_err", wr_err, 0);
        step();

        // Write during RUN is dropped and flags wr_err until the next start.
        num_runs = 1; hold_cycles = 1; run_cycles = 6; sample_cycles = 1;
        phase_in = 3'b001; bus.res_ready = 1'b1;
        sb_q.push_back({3'b001, 16'd0});
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        bus.host_wready = 1'b1; bus.host_wr_addr = 32'hDEAD_0010; bus.host_wdata = 32'h5555_AAAA;
        #1;
        check("wr_run_gated", {bus.core_wready, bus.core_wr_addr}, 0);
        step();
        bus.host_wready = 1'b0;
        @(negedge clk);
        check("wr_err_set", wr_err, 1);
        step();
        wait_done(20);
        @(negedge clk);
        check("wr_err_sticky", wr_err, 1);
        step();

        // Abort during RUN; start arrives together with abort in IDLE and must be accepted.
        num_runs = 3; hold_cycles = 2; run_cycles = 10; sample_cycles = 1;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            abort = (k == 4);
            @(negedge clk);
            if (k <= 2)      e = 5'b00100;
            else if (k <= 4) e = 5'b10100;
            else if (k == 5) e = 5'b00001;
            else             e = 5'b00000;
            check($sformatf("abort_run_k%0d", k), st(), e);
            if (k == 1) check("wr_err_cleared", wr_err, 0);
        end
        step();

        // Abort coinciding with the second OUTPUT handshake: that result is not counted.
        num_runs = 2; hold_cycles = 1; run_cycles = 1; sample_cycles = 1;
        phase_in = 3'b101; bus.res_ready = 1'b1;
        sb_q.push_back({3'b101, 16'd0});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) step();
            abort = (k == 8);
            @(negedge clk);
            if (k == 1 || k == 5)      e = 5'b00100;
            else if (k == 4 || k == 8) e = 5'b11100;
            else if (k <= 7)           e = 5'b10100;
            else if (k == 9)           e = 5'b00001;
            else                       e = 5'b00000;
            check($sformatf("abort_hs_k%0d", k), st(), e);
        end
        step();

        // Asynchronous reset in the middle of SAMPLE.
        num_runs = 2; hold_cycles = 1; run_cycles = 1; sample_cycles = 5;
        phase_in = 3'b100;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_vals", {ising_rstn, busy, done, aborted, bus.res_valid, wr_err, bus.core_wready,
                                   bus.res_phase, bus.res_index, bus.core_wr_addr, bus.core_wdata}, 0);
        step();
        step();
        rstn = 1'b1;
        step();
        run_batch("post_reset", 1, 1, 1, 1, 3'b010);

        repeat (3) step();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
